mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam int unsigned STARVE_LIMIT_DEF = 3;
    localparam int unsigned MEM_BYTES_DEF    = 65536;
    localparam int unsigned ADDR_W           = 32;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned BE_W             = 4;

    // Word-aligned and inside the memory window; 33-bit compare allows a full 4 GiB window.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr, input logic [ADDR_W:0] mem_bytes);
        return (addr[1:0] == 2'b00) && ({1'b0, addr} < mem_bytes);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and memory port bundle of the arbiter.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [BE_W-1:0]   d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              mem_en;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: data has priority, fetch is protected from starvation.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned MEM_BYTES    = MEM_BYTES_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic              resp_fetch;
    logic              resp_store;
    logic              resp_err;
    logic              gnt_if;
    logic              gnt_d;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_legal;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and grant decision; grants are suppressed while reset is held
    always_comb begin
        state_nxt = state;
        gnt_if    = 1'b0;
        gnt_d     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rst) begin
                    if (bus.if_req && (!bus.d_req || (starve_cnt == CNT_W'(STARVE_LIMIT)))) begin
                        gnt_if = 1'b1;
                    end else if (bus.d_req) begin
                        gnt_d = 1'b1;
                    end
                end
                if (gnt_if || gnt_d) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        sel_addr  = gnt_d ? bus.d_addr : bus.if_addr;
        sel_legal = addr_legal(sel_addr, (ADDR_W+1)'(MEM_BYTES));
    end

    // Starvation counter and the attributes of the single outstanding access
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            resp_fetch <= 1'b0;
            resp_store <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            if (gnt_if || !bus.if_req) begin
                starve_cnt <= '0;
            end else if (gnt_d) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
            if (gnt_if || gnt_d) begin
                resp_fetch <= gnt_if;
                resp_store <= gnt_d & bus.d_we;
                resp_err   <= ~sel_legal;
            end
        end
    end

    // Outputs: memory strobe in the grant cycle, response on the granted port in RESP
    always_comb begin
        bus.if_gnt    = gnt_if;
        bus.d_gnt     = gnt_d;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.if_rvalid = 1'b0;
        bus.if_err    = 1'b0;
        bus.if_rdata  = '0;
        bus.d_rvalid  = 1'b0;
        bus.d_err     = 1'b0;
        bus.d_rdata   = '0;
        if ((gnt_if || gnt_d) && sel_legal) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = gnt_d & bus.d_we;
            bus.mem_be    = (gnt_d && bus.d_we) ? bus.d_be : 4'hF;
            bus.mem_addr  = sel_addr;
            bus.mem_wdata = bus.d_wdata;
        end
        if (!rst && (state == RESP)) begin
            if (resp_fetch) begin
                bus.if_rvalid = 1'b1;
                bus.if_err    = resp_err;
                bus.if_rdata  = resp_err ? '0 : bus.mem_rdata;
            end else begin
                bus.d_rvalid = 1'b1;
                bus.d_err    = resp_err;
                bus.d_rdata  = (resp_err || resp_store) ? '0 : bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned LIMIT = 3;
    localparam int unsigned MEMB  = 65536;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .MEM_BYTES(MEMB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Deterministic power-up contents shared by the memory and the reference copy
    function automatic logic [7:0] init_byte(input int unsigned i);
        case (i)
            32'h100: return 8'h93;
            32'h101: return 8'h00;
            32'h102: return 8'h50;
            32'h103: return 8'h00;
            32'h200: return 8'h11;
            32'h201: return 8'h22;
            32'h202: return 8'h33;
            32'h203: return 8'h44;
            default: return 8'((i * 7919 + 13) ^ (i >> 8));
        endcase
    endfunction

    // Memory: one-cycle read latency, garbage on the read bus when idle
    logic [7:0]  env_mem [MEMB];
    bit          env_ready = 1'b0;
    int unsigned env_a;
    always @(posedge clk) begin
        if (!env_ready) begin
            for (int i = 0; i < int'(MEMB); i++) env_mem[i] <= init_byte(i);
            env_ready <= 1'b1;
        end
        env_a = 32'(bus.mem_addr[15:0]) & 32'hFFFC;
        if (bus.mem_en) begin
            bus.mem_rdata <= {env_mem[env_a+3], env_mem[env_a+2], env_mem[env_a+1], env_mem[env_a]};
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) env_mem[env_a+b] <= bus.mem_wdata[8*b +: 8];
            end
        end else begin
            bus.mem_rdata <= $urandom();
        end
    end

    // Reference model state
    logic [7:0]  ref_mem [MEMB];
    bit          busy, p_fetch, p_err;
    logic [31:0] p_data;
    int unsigned starve;
    bit          g_if, g_d;
    logic        o_ifg, o_dg, o_ifv, o_dv, o_derr, o_en;
    logic [31:0] o_if_rdata, o_d_rdata;

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int unsigned i = 32'(a[15:0]);
        return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
    endfunction

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < MEMB);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: predict from current inputs, compare at negedge, advance past posedge
    task automatic run_cycle();
        logic        e_en, e_we, e_ifv, e_dv, e_iferr, e_derr;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wd, e_ifd, e_dd, a;
        @(negedge clk);
        {e_en, e_we, e_ifv, e_dv, e_iferr, e_derr} = '0;
        e_be = '0; e_addr = '0; e_wd = '0; e_ifd = '0; e_dd = '0;
        g_if = 1'b0;
        g_d  = 1'b0;
        if (rst) begin
            chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
            busy   = 1'b0;
            starve = 0;
        end else begin
            if (busy) begin
                if (p_fetch) begin
                    e_ifv = 1'b1; e_iferr = p_err; e_ifd = p_data;
                end else begin
                    e_dv = 1'b1; e_derr = p_err; e_dd = p_data;
                end
                busy = 1'b0;
            end else if (bus.if_req || bus.d_req) begin
                g_if    = bus.if_req && (!bus.d_req || starve >= LIMIT);
                g_d     = !g_if;
                a       = g_if ? bus.if_addr : bus.d_addr;
                p_fetch = g_if;
                p_err   = !legal(a);
                busy    = 1'b1;
                p_data  = '0;
                if (!p_err) begin
                    e_en   = 1'b1;
                    e_addr = a;
                    e_we   = g_d && bus.d_we;
                    e_be   = e_we ? bus.d_be : 4'hF;
                    e_wd   = bus.d_wdata;
                    if (e_we) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.d_be[b]) ref_mem[32'(a[15:0]) + b] = bus.d_wdata[8*b +: 8];
                    end else begin
                        p_data = ref_word(a);
                    end
                end
            end
            if (!bus.if_req || g_if) starve = 0;
            else if (g_d) starve++;

            chk("if_gnt", 32'(bus.if_gnt), 32'(g_if));
            chk("d_gnt", 32'(bus.d_gnt), 32'(g_d));
            chk("mem_en", 32'(bus.mem_en), 32'(e_en));
            chk("mem_we", 32'(bus.mem_we), 32'(e_we));
            chk("mem_be", 32'(bus.mem_be), 32'(e_be));
            chk("mem_addr", bus.mem_addr, e_addr);
            chk("mem_wdata", bus.mem_wdata, e_wd);
            chk("if_rvalid", 32'(bus.if_rvalid), 32'(e_ifv));
            chk("d_rvalid", 32'(bus.d_rvalid), 32'(e_dv));
            if (e_ifv) begin
                chk("if_err", 32'(bus.if_err), 32'(e_iferr));
                chk("if_rdata", bus.if_rdata, e_ifd);
            end
            if (e_dv) begin
                chk("d_err", 32'(bus.d_err), 32'(e_derr));
                chk("d_rdata", bus.d_rdata, e_dd);
            end
        end
        o_ifg = bus.if_gnt;  o_dg = bus.d_gnt;
        o_ifv = bus.if_rvalid; o_dv = bus.d_rvalid;
        o_derr = bus.d_err;  o_en = bus.mem_en;
        o_if_rdata = bus.if_rdata; o_d_rdata = bus.d_rdata;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r = $urandom_range(0, 19);
        if (r == 0) return 32'h10000 + 4 * $urandom_range(0, 7);
        if (r == 1) return 32'h200 + $urandom_range(1, 3);
        if (r == 2) return $urandom();
        return 32'h200 + 4 * $urandom_range(0, 15);
    endfunction

    initial begin
        bit fp, dp;
        for (int i = 0; i < int'(MEMB); i++) ref_mem[i] = init_byte(i);
        busy = 1'b0; starve = 0; p_fetch = 1'b0; p_err = 1'b0; p_data = '0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
        rst = 1'b1;
        run_cycle();
        run_cycle();
        rst = 1'b0;
        run_cycle();
        run_cycle();

        // Fetch from 0x100
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        run_cycle();
        chk("fetch_gnt", 32'(o_ifg), 32'd1);
        bus.if_req = 1'b0;
        run_cycle();
        chk("fetch_rvalid", 32'(o_ifv), 32'd1);
        chk("fetch_word", o_if_rdata, 32'h0050_0093);

        // Partial store then load back
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
        bus.d_addr = 32'h200; bus.d_wdata = 32'hAABB_CCDD;
        run_cycle();
        bus.d_req = 1'b0;
        run_cycle();
        chk("store_ack", 32'(o_dv), 32'd1);
        chk("store_ack_rdata", o_d_rdata, 32'd0);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'h0;
        run_cycle();
        bus.d_req = 1'b0;
        run_cycle();
        chk("load_merge", o_d_rdata, 32'h4433_CCDD);

        // Both requesters saturated: D,D,D,F repeating
        bus.if_req = 1'b1; bus.if_addr = 32'h104;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h208;
        for (int i = 0; i < 16; i++) begin
            run_cycle();
            if (i % 2 == 0)
                chk("starve_pattern", 32'({o_ifg, o_dg}), ((i / 2) % 4 == 3) ? 32'd2 : 32'd1);
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        run_cycle();

        // Misaligned and out-of-window data accesses
        for (int k = 0; k < 2; k++) begin
            bus.d_req = 1'b1; bus.d_we = 1'b0;
            bus.d_addr = (k == 0) ? 32'h202 : 32'h1_0000;
            run_cycle();
            chk("bad_gnt", 32'(o_dg), 32'd1);
            chk("bad_no_en", 32'(o_en), 32'd0);
            bus.d_req = 1'b0;
            run_cycle();
            chk("bad_rvalid", 32'(o_dv), 32'd1);
            chk("bad_err", 32'(o_derr), 32'd1);
        end

        // Reset during a load response, fetch on the first free cycle
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        run_cycle();
        bus.d_req = 1'b0;
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        run_cycle();
        chk("post_rst_fgnt", 32'(o_ifg), 32'd1);
        chk("post_rst_no_dv", 32'(o_dv), 32'd0);
        bus.if_req = 1'b0;
        run_cycle();
        chk("post_rst_fword", o_if_rdata, 32'h0050_0093);
        chk("post_rst_no_dv2", 32'(o_dv), 32'd0);

        // Random traffic; requests held until the model grants them
        fp = 1'b0; dp = 1'b0;
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!fp && $urandom_range(0, 1) == 1) begin
                fp = 1'b1;
                bus.if_addr = rand_addr();
            end
            if (!dp && $urandom_range(0, 1) == 1) begin
                dp = 1'b1;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_be    = 4'($urandom());
                bus.d_addr  = rand_addr();
                bus.d_wdata = $urandom();
            end
            bus.if_req = fp;
            bus.d_req  = dp;
            run_cycle();
            if (g_if) fp = 1'b0;
            if (g_d)  dp = 1'b0;
        end
        rst = 1'b0;
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        run_cycle();
        run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
